// File: rtl/mod_counter_pkg.sv
// Shared definitions for the counter/timebase blocks: direction encoding and a
// constant-safe ceil(log2) helper for parameter checks.
package mod_counter_pkg;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // Number of bits needed to hold the values 0..value-1 (0 for value <= 1).
    function automatic int clog2(input int value);
        int v;
        int result;
        v      = value - 1;
        result = 0;
        while (v > 0) begin
            result = result + 1;
            v      = v >>> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/sat_event_counter.sv
// Saturating event tally: counts inc pulses, sticks at all-ones, synchronous clear,
// asynchronous active-low reset.
module sat_event_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mod_n_sync_counter.sv
// Synchronous modulo-N up/down counter with cascade tc, wrap pulse and saturating wrap tally.
// Define MODN_LOAD_EN to add the clamped parallel load (load/load_val).
module mod_n_sync_counter
    import mod_counter_pkg::*;
#(
    parameter int WIDTH      = 4,
    parameter int MODULUS    = 12,
    parameter int RESET_VAL  = 0,
    parameter int WRAP_CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  up,
    input  logic                  sclr,
`ifdef MODN_LOAD_EN
    input  logic                  load,
    input  logic [WIDTH-1:0]      load_val,
`endif
    output logic [WIDTH-1:0]      count,
    output logic                  tc,
    output logic                  wrap_pulse,
    output logic [WRAP_CNT_W-1:0] wrap_cnt
);

    if (MODULUS < 2 || clog2(MODULUS) > WIDTH) begin : g_bad_modulus
        $error("mod_n_sync_counter: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
    end
    if (RESET_VAL < 0 || RESET_VAL >= MODULUS) begin : g_bad_reset_val
        $error("mod_n_sync_counter: RESET_VAL must be below MODULUS");
    end

    localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] RST_CNT = WIDTH'(RESET_VAL);
`ifdef MODN_LOAD_EN
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);
`endif

    logic               at_max;
    logic               at_zero;
    logic               at_edge;
    logic [WIDTH-1:0]   next_count;
    logic               wrap_evt;

    assign at_max  = (count == MAX_CNT);
    assign at_zero = (count == '0);
    assign at_edge = (up == DIR_UP) ? at_max : at_zero;

    // Gated by reset so a held-in-reset stage never enables its downstream neighbour.
    assign tc = reset & en & at_edge;

    always_comb begin
        next_count = count;
        wrap_evt   = 1'b0;
        if (sclr) begin
            next_count = RST_CNT;
        end
`ifdef MODN_LOAD_EN
        else if (load) begin
            next_count = ({1'b0, load_val} < MOD_EXT) ? load_val : MAX_CNT;
        end
`endif
        else if (en) begin
            wrap_evt = at_edge;
            if (up == DIR_UP) begin
                next_count = at_max ? '0 : count + 1'b1;
            end else begin
                next_count = at_zero ? MAX_CNT : count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count      <= RST_CNT;
            wrap_pulse <= 1'b0;
        end else begin
            count      <= next_count;
            wrap_pulse <= wrap_evt;
        end
    end

    sat_event_counter #(
        .W(WRAP_CNT_W)
    ) u_wrap_tally (
        .clk  (clk),
        .rst_n(reset),
        .clr  (sclr),
        .inc  (wrap_evt),
        .cnt  (wrap_cnt)
    );

endmodule

// File: tb/tb_mod_n_sync_counter.sv
// Directed bench for mod_n_sync_counter: default mod-12 instance plus a mod-3 instance
// with a 2-bit wrap tally for saturation.
module tb_mod_n_sync_counter;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT: defaults (WIDTH 4, MODULUS 12) ----------------
    logic       en = 1'b1, up = 1'b0, sclr = 1'b0;
    logic       load = 1'b0;
    logic [3:0] load_val = '0;
    logic [3:0] count;
    logic       tc, wrap_pulse;
    logic [7:0] wrap_cnt;

    mod_n_sync_counter dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .up        (up),
        .sclr      (sclr),
`ifdef MODN_LOAD_EN
        .load      (load),
        .load_val  (load_val),
`endif
        .count     (count),
        .tc        (tc),
        .wrap_pulse(wrap_pulse),
        .wrap_cnt  (wrap_cnt)
    );

    // ---------------- DUT2: MODULUS 3, 2-bit tally ----------------
    logic       en2 = 1'b0, up2 = 1'b1, sclr2 = 1'b0;
    logic       load2 = 1'b0;
    logic [1:0] load_val2 = '0;
    logic [1:0] count2;
    logic       tc2, wrap_pulse2;
    logic [1:0] wrap_cnt2;

    mod_n_sync_counter #(
        .WIDTH(2), .MODULUS(3), .RESET_VAL(0), .WRAP_CNT_W(2)
    ) dut2 (
        .clk       (clk),
        .reset     (reset),
        .en        (en2),
        .up        (up2),
        .sclr      (sclr2),
`ifdef MODN_LOAD_EN
        .load      (load2),
        .load_val  (load_val2),
`endif
        .count     (count2),
        .tc        (tc2),
        .wrap_pulse(wrap_pulse2),
        .wrap_cnt  (wrap_cnt2)
    );

    // ---------------- scoreboard ----------------
    int tests_run = 0;
    int tests_failed = 0;
    logic [3:0] exp_q[$];   // {count2, wrap_cnt2} expected after each dut2 edge

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        logic       en;
        logic       up;
        logic       sclr;
        logic [3:0] cnt;
        logic       tc;
        logic       wp;
        logic [7:0] wc;
    } vec_t;
    vec_t vecs[$];

    function automatic void add(input logic e, input logic u, input logic s, input logic [3:0] c,
                                input logic t, input logic w, input logic [7:0] n);
        vec_t v;
        v.en = e; v.up = u; v.sclr = s; v.cnt = c; v.tc = t; v.wp = w; v.wc = n;
        vecs.push_back(v);
    endfunction

    // ---------------- driver tasks ----------------
    // Apply inputs, take one edge, sample 2ns later (well clear of the edge).
    task automatic step(input logic e, input logic u, input logic s);
        en = e; up = u; sclr = s;
        @(posedge clk);
        #2;
    endtask

    task automatic check_all(input string tag, input logic [3:0] c, input logic t,
                             input logic w, input logic [7:0] n);
        check({tag, ".count"}, 32'(count), 32'(c));
        check({tag, ".tc"}, 32'(tc), 32'(t));
        check({tag, ".wrap_pulse"}, 32'(wrap_pulse), 32'(w));
        check({tag, ".wrap_cnt"}, 32'(wrap_cnt), 32'(n));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int wp_seen;
        logic [1:0] m_cnt;
        logic [1:0] m_wc;
        logic [3:0] e;

        // ---- reset state (en=1, up=0, count=0 would raise tc if not gated) ----
        #50;
        check_all("reset", 4'd0, 1'b0, 1'b0, 8'd0);
        up = 1'b1;
        #50 reset = 1'b1;

        // ---- table: up to wrap, sclr, down wrap, hold, direction changes ----
        for (int k = 1; k <= 11; k++) add(1, 1, 0, 4'(k), k == 11, 0, 0);
        add(1, 1, 0, 4'd0, 0, 1, 1);
        add(1, 1, 0, 4'd1, 0, 0, 1);
        add(1, 1, 1, 4'd0, 0, 0, 0);
        add(1, 0, 0, 4'd11, 0, 1, 1);
        add(1, 0, 0, 4'd10, 0, 0, 1);
        add(1, 0, 0, 4'd9, 0, 0, 1);
        add(1, 0, 0, 4'd8, 0, 0, 1);
        add(1, 0, 0, 4'd7, 0, 0, 1);
        add(0, 0, 0, 4'd7, 0, 0, 1);
        add(0, 0, 0, 4'd7, 0, 0, 1);
        add(0, 1, 0, 4'd7, 0, 0, 1);
        add(1, 1, 0, 4'd8, 0, 0, 1);
        add(1, 1, 0, 4'd9, 0, 0, 1);
        add(1, 1, 0, 4'd10, 0, 0, 1);
        add(1, 1, 0, 4'd11, 1, 0, 1);
        add(1, 0, 0, 4'd10, 0, 0, 1);
        add(0, 1, 0, 4'd10, 0, 0, 1);
        add(0, 1, 1, 4'd0, 0, 0, 0);
        add(1, 0, 0, 4'd11, 0, 1, 1);
        add(1, 1, 0, 4'd0, 0, 1, 2);
        add(1, 1, 0, 4'd1, 0, 0, 2);

        foreach (vecs[i]) begin
            step(vecs[i].en, vecs[i].up, vecs[i].sclr);
            check_all($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].tc, vecs[i].wp, vecs[i].wc);
        end

        // ---- asynchronous reset mid-count ----
        step(1, 1, 1);
        for (int k = 0; k < 5; k++) step(1, 1, 0);
        check("pre_areset.count", 32'(count), 32'd5);
        reset = 1'b0;
        #1;
        check_all("areset", 4'd0, 1'b0, 1'b0, 8'd0);
        #9 reset = 1'b1;
        step(1, 1, 0);
        check("areset_resume1.count", 32'(count), 32'd1);
        step(1, 1, 0);
        check("areset_resume2.count", 32'(count), 32'd2);

`ifdef MODN_LOAD_EN
        // ---- parallel load ----
        load = 1'b1; load_val = 4'd7;
        step(1, 1, 0);
        check_all("load7", 4'd7, 1'b0, 1'b0, 8'd0);
        load_val = 4'd14;
        step(1, 1, 0);
        check_all("load14", 4'd11, 1'b1, 1'b0, 8'd0);
        load = 1'b0;
        step(1, 1, 0);
        check_all("after_load_wrap", 4'd0, 1'b0, 1'b1, 8'd1);
        load = 1'b1; load_val = 4'd3;
        step(1, 1, 0);
        check_all("load3_keep_tally", 4'd3, 1'b0, 1'b0, 8'd1);
        load_val = 4'd7;
        step(1, 1, 1);
        check_all("sclr_over_load", 4'd0, 1'b0, 1'b0, 8'd0);
        load = 1'b0;
`endif

        // ---- mod-3 instance, 2-bit tally saturation over 18 edges ----
        en = 1'b0;
        sclr2 = 1'b1; en2 = 1'b1; up2 = 1'b1;
        @(posedge clk);
        #2;
        sclr2 = 1'b0;
        check("dut2_clear.count", 32'(count2), 32'd0);
        m_cnt = 2'd0;
        m_wc = 2'd0;
        wp_seen = 0;
        for (int k = 0; k < 18; k++) begin
            if (m_cnt == 2'd2) begin
                m_cnt = 2'd0;
                if (m_wc != 2'd3) m_wc = m_wc + 2'd1;
            end else begin
                m_cnt = m_cnt + 2'd1;
            end
            exp_q.push_back({m_cnt, m_wc});
            @(posedge clk);
            #2;
            if (wrap_pulse2) wp_seen++;
            e = exp_q.pop_front();
            check($sformatf("dut2_e%0d.count", k), 32'(count2), 32'(e[3:2]));
            check($sformatf("dut2_e%0d.wrap_cnt", k), 32'(wrap_cnt2), 32'(e[1:0]));
        end
        check("dut2_wrap_pulses", 32'(wp_seen), 32'd6);
        check("dut2_saturated", 32'(wrap_cnt2), 32'd3);
        en2 = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
